boolean_proposal_driver: RTL

// - Requester side of the BooleanPropose interface. Owns the committed boolean assignment register.
// - Per move: picks a variable index, drives the proposer and captures its flipped-bit proposal.
// - Holds the proposal for the accept/reject stage, then commits it or discards it.
// - Sits between the MCMC sweep controller (start/decision) and the combinational BooleanPropose block.

---
 rtl/boolean_proposal_driver.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/boolean_proposal_driver.sv
// boolean_proposal_driver: requester side of the BooleanPropose interface.
// Owns the committed boolean assignment, picks a variable index per move,
// captures the flipped-bit proposal from the combinational proposer, holds it
// for the accept/reject decision, then commits or discards it.
// Build option: define ROUND_ROBIN_INDEX_EN to replace the 16-bit Galois LFSR
// index source with a wrapping round-robin counter.
module boolean_proposal_driver #(
  parameter int          NUMBER_OF_BOOLEAN_VARIABLES = 2,
  parameter int          INDEX_WIDTH                 = 1,
  parameter logic [15:0] LFSR_SEED                   = 16'hACE1
) (
  input  logic                                   in_clk,
  input  logic                                   in_reset,
  input  logic                                   in_load,
  input  logic [NUMBER_OF_BOOLEAN_VARIABLES-1:0] in_initial_assignment_boolean,
  input  logic                                   in_start,
  input  logic [NUMBER_OF_BOOLEAN_VARIABLES-1:0] in_new_assignment_boolean,
  input  logic                                   in_decision_valid,
  input  logic                                   in_accept,
  output logic [NUMBER_OF_BOOLEAN_VARIABLES-1:0] out_current_assignment_boolean,
  output logic [INDEX_WIDTH-1:0]                 out_variable_to_be_changed_index,
  output logic                                   out_enable,
  output logic [NUMBER_OF_BOOLEAN_VARIABLES-1:0] out_proposed_assignment_boolean,
  output logic                                   out_proposal_valid,
  output logic                                   out_ready,
  output logic                                   out_done,
  output logic                                   out_proposal_error
);

  localparam int N  = NUMBER_OF_BOOLEAN_VARIABLES;
  localparam int IW = INDEX_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PROPOSE = 2'd1,
    S_WAIT    = 2'd2,
    S_COMMIT  = 2'd3
  } state_t;

  state_t          state_q,    state_d;
  logic [N-1:0]    current_q,  current_d;
  logic [IW-1:0]   index_q,    index_d;
  logic            enable_q,   enable_d;
  logic [N-1:0]    proposal_q, proposal_d;
  logic            valid_q,    valid_d;
  logic            ready_q,    ready_d;
  logic            done_q,     done_d;
  logic            error_q,    error_d;

  logic [IW-1:0]   pick;
  logic [N-1:0]    onehot;

`ifdef ROUND_ROBIN_INDEX_EN
  logic [IW-1:0]   rr_q, rr_d, rr_next;

  // Round-robin index source: next value wraps from N-1 back to 0
  always_comb begin
    pick    = rr_q;
    rr_next = (32'(rr_q) == 32'(N - 1)) ? '0 : rr_q + IW'(1);
  end
`else
  logic [15:0]     lfsr_q, lfsr_d, lfsr_next;
  logic [31:0]     raw_ext;

  // Galois LFSR index source: low IW bits folded into 0..N-1
  always_comb begin
    lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    raw_ext   = 32'(lfsr_q[IW-1:0]);
    if (raw_ext >= 32'(N)) pick = IW'(raw_ext - 32'(N));
    else                   pick = lfsr_q[IW-1:0];
  end
`endif

  // Expected flip pattern for the currently registered index
  always_comb begin
    onehot = {{(N-1){1'b0}}, 1'b1} << index_q;
  end

  // Next-state and next-output computation for the move sequencer
  always_comb begin
    state_d    = state_q;
    current_d  = current_q;
    index_d    = index_q;
    enable_d   = 1'b0;
    proposal_d = proposal_q;
    valid_d    = valid_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    error_d    = error_q;
`ifdef ROUND_ROBIN_INDEX_EN
    rr_d       = rr_q;
`else
    lfsr_d     = lfsr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_load) begin
          current_d = in_initial_assignment_boolean;
        end else if (in_start) begin
          index_d  = pick;
          enable_d = 1'b1;
          ready_d  = 1'b0;
          state_d  = S_PROPOSE;
        end
      end
      S_PROPOSE: begin
        // Proposal is captured even when malformed; the error flag is sticky
        proposal_d = in_new_assignment_boolean;
        valid_d    = 1'b1;
        if ((in_new_assignment_boolean ^ current_q) != onehot) error_d = 1'b1;
`ifdef ROUND_ROBIN_INDEX_EN
        rr_d       = rr_next;
`else
        lfsr_d     = lfsr_next;
`endif
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (in_decision_valid) begin
          if (in_accept) current_d = proposal_q;
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset aborts any move in flight
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q    <= S_IDLE;
      current_q  <= '0;
      index_q    <= '0;
      enable_q   <= 1'b0;
      proposal_q <= '0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef ROUND_ROBIN_INDEX_EN
      rr_q       <= '0;
`else
      lfsr_q     <= LFSR_SEED;
`endif
    end else begin
      state_q    <= state_d;
      current_q  <= current_d;
      index_q    <= index_d;
      enable_q   <= enable_d;
      proposal_q <= proposal_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef ROUND_ROBIN_INDEX_EN
      rr_q       <= rr_d;
`else
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  assign out_current_assignment_boolean   = current_q;
  assign out_variable_to_be_changed_index = index_q;
  assign out_enable                       = enable_q;
  assign out_proposed_assignment_boolean  = proposal_q;
  assign out_proposal_valid               = valid_q;
  assign out_ready                        = ready_q;
  assign out_done                         = done_q;
  assign out_proposal_error               = error_q;

endmodule
